// File: rtl/image_scroller.sv
// image_scroller: holds a host-written column message and presents a scrolling
// TOTAL_COLUNES-wide window of it to the LED matrix displayer.
// Optional feature macro: IMAGE_SCROLLER_REVERSE_EN adds a `dir` input that
// lets the window scroll backward.
module image_scroller #(
    parameter int unsigned COLUNE_SIZE   = 7,
    parameter int unsigned TOTAL_COLUNES = 5,
    parameter int unsigned DATA_WIDTH    = 35,
    parameter int unsigned MAX_COLUNES   = 16,
    parameter int unsigned ADDR_WIDTH    = 4,
    parameter int unsigned TICK_DIV      = 24
) (
    input  logic                     clk,
    input  logic                     reset,
`ifdef IMAGE_SCROLLER_REVERSE_EN
    input  logic                     dir,
`endif
    input  logic                     wr_en,
    input  logic [ADDR_WIDTH-1:0]    wr_addr,
    input  logic [COLUNE_SIZE-1:0]   wr_data,
    input  logic [ADDR_WIDTH:0]      msg_len,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     hold,
    output logic [DATA_WIDTH-1:0]    image,
    output logic                     display_enable,
    output logic                     step,
    output logic                     wrap
);

    localparam int unsigned LEN_W = ADDR_WIDTH + 1;
    localparam int unsigned DIV_W = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HOLD
    } state_t;

    state_t                  state_q, state_d;
    logic [COLUNE_SIZE-1:0]  col_mem [MAX_COLUNES];
    logic [LEN_W-1:0]        len_q, len_d;
    logic [ADDR_WIDTH-1:0]   off_q, off_d, off_nx;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [DATA_WIDTH-1:0]   image_d, win;
    logic                    en_d, step_d, wrap_d, wrap_nx;
    logic                    start_ok;
    logic [ADDR_WIDTH-1:0]   win_off;
    logic [LEN_W-1:0]        win_len;

    assign start_ok = start && (msg_len != '0) && (32'(msg_len) <= MAX_COLUNES);

    // Message buffer; deliberately untouched by reset, out-of-range writes dropped.
    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_addr) < MAX_COLUNES)) begin
            col_mem[wr_addr] <= wr_data;
        end
    end

    // Offset reached by the next scroll step, and whether that step wraps.
    always_comb begin
        off_nx  = (32'(off_q) + 32'd1 >= 32'(len_q)) ? '0 : off_q + ADDR_WIDTH'(1);
        wrap_nx = (off_nx == '0);
`ifdef IMAGE_SCROLLER_REVERSE_EN
        if (dir) begin
            off_nx  = (off_q == '0) ? ADDR_WIDTH'(len_q - LEN_W'(1)) : off_q - ADDR_WIDTH'(1);
            wrap_nx = (32'(off_nx) + 32'd1 == 32'(len_q));
        end
`endif
    end

    // A restart loads the window at offset 0 of the new length; otherwise the step window.
    assign win_off = (start_ok && !stop) ? '0 : off_nx;
    assign win_len = (start_ok && !stop) ? msg_len : len_q;

    // Window gather: column i = col_mem[(win_off + i) mod win_len], reduced by subtraction.
    always_comb begin
        int unsigned idx;
        win = '0;
        idx = 0;
        for (int unsigned i = 0; i < TOTAL_COLUNES; i++) begin
            idx = 32'(win_off) + i;
            for (int unsigned k = 0; k < TOTAL_COLUNES; k++) begin
                if (idx >= 32'(win_len)) begin
                    idx = idx - 32'(win_len);
                end
            end
            win[i*COLUNE_SIZE +: COLUNE_SIZE] = col_mem[ADDR_WIDTH'(idx)];
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and next datapath/output values; stop > start > hold > divider.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        off_d   = off_q;
        div_d   = div_q;
        image_d = image;
        en_d    = display_enable;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        if (stop) begin
            state_d = ST_IDLE;
            off_d   = '0;
            div_d   = '0;
            image_d = '0;
            en_d    = 1'b0;
        end else if (start_ok) begin
            state_d = hold ? ST_HOLD : ST_RUN;
            len_d   = msg_len;
            off_d   = '0;
            div_d   = '0;
            image_d = win;
            en_d    = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    image_d = '0;
                    en_d    = 1'b0;
                end
                ST_RUN, ST_HOLD: begin
                    if (hold) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_RUN;
                        if (div_q == DIV_LAST) begin
                            div_d   = '0;
                            off_d   = off_nx;
                            image_d = win;
                            step_d  = 1'b1;
                            wrap_d  = wrap_nx;
                        end else begin
                            div_d = div_q + DIV_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    image_d = '0;
                    en_d    = 1'b0;
                end
            endcase
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q          <= '0;
            off_q          <= '0;
            div_q          <= '0;
            image          <= '0;
            display_enable <= 1'b0;
            step           <= 1'b0;
            wrap           <= 1'b0;
        end else begin
            len_q          <= len_d;
            off_q          <= off_d;
            div_q          <= div_d;
            image          <= image_d;
            display_enable <= en_d;
            step           <= step_d;
            wrap           <= wrap_d;
        end
    end

endmodule

// File: doc/image_scroller.md
# image_scroller

Upstream feeder for the column-scanned LED matrix displayer. Holds a message of up to MAX_COLUNES 7-bit columns written by the host. Presents a TOTAL_COLUNES-wide window of that message as a registered 35-bit `image` plus a matching `display_enable`. Advances the window one column every TICK_DIV clocks, wrapping around the message end, so text scrolls across the 5×7 matrix.

## Interface
Parameters:
- COLUNE_SIZE, 7, bits per column (matrix rows)
- TOTAL_COLUNES, 5, columns visible in the window
- DATA_WIDTH, 35, width of `image`; must equal COLUNE_SIZE*TOTAL_COLUNES
- MAX_COLUNES, 16, message buffer depth in columns
- ADDR_WIDTH, 4, buffer address width; 2^ADDR_WIDTH ≥ MAX_COLUNES
- TICK_DIV, 24, clocks per scroll step; ≥2

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- wr_en  in  1  write `wr_data` into buffer at `wr_addr`
- wr_addr  in  ADDR_WIDTH  column address; writes with wr_addr ≥ MAX_COLUNES are dropped
- wr_data  in  COLUNE_SIZE  column pattern
- msg_len  in  ADDR_WIDTH+1  message length in columns, sampled on `start`
- start  in  1  begin or restart scrolling at offset 0
- stop  in  1  return to IDLE
- hold  in  1  level; freeze scrolling while high
- image  out  DATA_WIDTH  window; column i occupies bits [7i+6:7i]
- display_enable  out  1  high in RUN and HOLD; drives the displayer enable
- step  out  1  one-cycle pulse after each window advance
- wrap  out  1  one-cycle pulse when the offset returns to 0

## Operation
- Buffer: MAX_COLUNES×COLUNE_SIZE register array, not cleared by reset. Writes are accepted in every state.
- Registered state: `len_q` (latched msg_len), `offset` (0..len_q-1), and divider `div` (0..TICK_DIV-1).
- Window: column i = buf[(offset+i) mod len_q] for i = 0..TOTAL_COLUNES-1. When len_q < TOTAL_COLUNES, columns repeat.
- States:
  - IDLE: image=0, display_enable=0.
  - RUN: div counts up. When div = TICK_DIV-1: div←0, offset←(offset+1) mod len_q, image←new window.
  - HOLD: div, offset and image are frozen.
- Transitions:
  - IDLE→RUN on start with 1 ≤ msg_len ≤ MAX_COLUNES. Otherwise start is ignored and state is unchanged (valid-length rule applies in every state).
  - RUN→HOLD when hold=1. HOLD→RUN when hold=0; the divider resumes from its frozen value.
  - Any state→IDLE on stop.
  - start in RUN or HOLD with a valid length: restart with offset=0, div=0, new len_q; next state is RUN, or HOLD if hold=1.
- Priority: reset > stop > start > hold > divider step.
- wrap asserts together with step when the new offset is 0. With len_q=1, every step also pulses wrap.

## Timing
- Reset values: state IDLE, image=0, display_enable=0, step=0, wrap=0, offset=0, div=0, len_q=0.
- Start accepted at edge k:
  - After edge k: state RUN, image=window(0), display_enable=1.
  - First advance at edge k+TICK_DIV; step and wrap are visible for exactly the cycle after that edge.
- Write/read collision: a window load on the same edge as a write to a column in that window uses the old buffer contents. The new value appears at the next window load.
- stop at edge k: image=0 and display_enable=0 after edge k. step and wrap are forced low.
- Reset asserted mid-run clears all outputs immediately (asynchronously). Buffer contents survive reset.

## Configuration
- IMAGE_SCROLLER_REVERSE_EN defined:
  - Adds input port `dir` (1 bit).
  - dir=1 makes each step set offset←(offset-1) mod len_q; going from 0 gives len_q-1.
  - wrap pulses when the new offset is len_q-1 while moving backward.
  - dir is sampled on the step edge.
- Not defined: no `dir` port; offset only increments.

## Test plan
1. Reset: assert reset mid-cycle → image=0, display_enable=0, step=0, wrap=0 immediately. All stay 0 after release with no start.
2. Load cols 0..7 = 0x01..0x08, msg_len=8, start (TICK_DIV=4):
   - after start edge, image = {0x05,0x04,0x03,0x02,0x01} (col0 in LSBs), display_enable=1;
   - 4 clocks later, step pulses for 1 cycle and image = {0x06,…,0x02}.
3. Continue from test 2:
   - at offset 6, image = {0x03,0x02,0x01,0x08,0x07};
   - the 8th step gives offset 0, and wrap and step pulse in the same cycle.
4. hold=1 for 10 clocks after 2 divider counts → image unchanged, no step. After hold=0, step occurs exactly 2 clocks later.
5. start with msg_len=0 or 17 from IDLE → stays IDLE, display_enable=0. stop and start in the same cycle during RUN → IDLE, image=0.
6. With IMAGE_SCROLLER_REVERSE_EN, dir=1, len=8, from offset 0 → after one step, offset=7, image = {0x04,0x03,0x02,0x01,0x08}, wrap pulses.
